// File: rtl/pic_inta_sequencer_pkg.sv
// ============================================================================
// Module   : pic_inta_sequencer_pkg
// Purpose  : Shared state encodings and constants for the INTA sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pic_inta_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_GAP   = 3'd2,
        ST_VALID = 3'd3,
        ST_REARM = 3'd4
    } state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    localparam int         NPULSE_8086 = 2;
    localparam int         NPULSE_8080 = 3;

    function automatic int npulse(input bit mode_8086);
        return mode_8086 ? NPULSE_8086 : NPULSE_8080;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic_inta_sequencer_if.sv
// ============================================================================
// Module   : pic_inta_sequencer_if
// Purpose  : PIC-side INT/INTA/data signals plus the core-side vector handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pic_inta_sequencer_if;
    logic        int_i;
    logic [7:0]  d_i;
    logic        inta_n;
    logic [15:0] vec_o;
    logic        vec_valid;
    logic        vec_ready;
    logic        op_err;

    modport master (
        input  int_i, d_i, vec_ready,
        output inta_n, vec_o, vec_valid, op_err
    );

    modport slave (
        output int_i, d_i, vec_ready,
        input  inta_n, vec_o, vec_valid, op_err
    );
endinterface

`default_nettype wire

// File: rtl/pic_inta_sequencer_sync2.sv
// ============================================================================
// Module   : pic_inta_sequencer_sync2
// Purpose  : Two-flop synchroniser for the asynchronous PIC INT line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pic_inta_sequencer_sync2 (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pic_inta_sequencer.sv
// ============================================================================
// Module   : pic_inta_sequencer
// Purpose  : Drives the 8259 INTA pulse train and hands the captured vector to the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pic_inta_sequencer
    import pic_inta_sequencer_pkg::*;
#(
    parameter bit MODE_8086 = 1'b1,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en_i,
    output logic                  busy,
    pic_inta_sequencer_if.master  bus
);

    localparam int         c_npulse     = npulse(MODE_8086);
    localparam logic [1:0] c_last_pidx  = 2'(c_npulse - 1);
    localparam logic [3:0] c_pulse_load = 4'(PULSE_CYC - 1);
    localparam logic [3:0] c_gap_load   = 4'(GAP_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_pidx;
    logic [7:0]  r_byte [3];

    logic        w_int_s;
    logic [7:0]  w_bytes [3];
    logic [15:0] w_vec;
    logic        w_err;

    pic_inta_sequencer_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.int_i),
        .q     (w_int_s)
    );

    // The last byte is still on d_i at the capture edge, so the vector is built
    // from the stored bytes with the current slot overlaid by d_i.
    always_comb begin
        w_bytes         = r_byte;
        w_bytes[r_pidx] = bus.d_i;
        if (MODE_8086) begin
            w_vec = {8'h00, w_bytes[1]};
            w_err = 1'b0;
        end else begin
            w_vec = {w_bytes[2], w_bytes[1]};
            w_err = (w_bytes[0] != CALL_OPCODE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_pidx        <= 2'd0;
            r_byte        <= '{default: 8'h00};
            bus.inta_n    <= 1'b1;
            bus.vec_o     <= 16'h0000;
            bus.vec_valid <= 1'b0;
            bus.op_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_int_s && en_i) begin
                        r_state    <= ST_PULSE;
                        r_pidx     <= 2'd0;
                        r_cnt      <= c_pulse_load;
                        bus.inta_n <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_byte[r_pidx] <= bus.d_i;
                        bus.inta_n     <= 1'b1;
                        if (r_pidx == c_last_pidx) begin
                            r_state       <= ST_VALID;
                            bus.vec_o     <= w_vec;
                            bus.op_err    <= w_err;
                            bus.vec_valid <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= c_gap_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= ST_PULSE;
                        r_pidx     <= r_pidx + 2'd1;
                        r_cnt      <= c_pulse_load;
                        bus.inta_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_VALID: begin
                    if (bus.vec_ready) begin
                        r_state       <= ST_REARM;
                        r_cnt         <= c_gap_load;
                        bus.vec_valid <= 1'b0;
                    end
                end
                ST_REARM: begin
                    // Hold off so the PIC has time to drop INT before we look again.
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    bus.inta_n <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire
